// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 step timing path: FSM encoding,
// commutation index range and default counter width.
package motoro3_pkg;

    localparam int unsigned CNT_W_DEF = 25;
    localparam logic [2:0]  STEP_LAST = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/motoro3_step_index.sv
// Six-step commutation index: registered 0..STEP_LAST up/down wrap counter.
// wrap_o flags the advance that crosses the 5/0 seam in either direction.
module motoro3_step_index
    import motoro3_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       adv_i,
    input  logic       dir_i,
    output logic [2:0] step_o,
    output logic       wrap_o
);

    logic [2:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        wrap_o = 1'b0;
        if (adv_i) begin
            if (dir_i) begin
                if (step_q == 3'd0) begin
                    step_d = STEP_LAST;
                    wrap_o = 1'b1;
                end else begin
                    step_d = step_q - 3'd1;
                end
            end else begin
                if (step_q >= STEP_LAST) begin
                    step_d = 3'd0;
                    wrap_o = 1'b1;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/motoro3_step_timer.sv
// Step timer: double-buffered period, per-step down-counter with end-of-step
// strobe, commutation index and revolution counter.
module motoro3_step_timer
    import motoro3_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned PERIOD_MIN = 1000,
    parameter int unsigned REV_W      = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             m3r_enable,
    input  logic             m3r_dir,
    input  logic [CNT_W-1:0] m3r_stepPeriod,
    input  logic             m3r_periodLoad,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntLast1,
    output logic [2:0]       m3step,
    output logic             m3stepValid,
    output logic             m3busy,
    output logic [CNT_W-1:0] m3periodActive,
    output logic [REV_W-1:0] m3revCnt
);

    localparam logic [CNT_W-1:0] PMIN = CNT_W'(PERIOD_MIN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic             last1_q, last1_d;

    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] reload;
    logic             running;
    logic             boundary;
    logic             wrap;

    // A load strobed in the reload cycle bypasses the shadow register.
    assign clamped  = (m3r_stepPeriod < PMIN) ? PMIN : m3r_stepPeriod;
    assign reload   = m3r_periodLoad ? clamped : shadow_q;
    assign running  = (state_q == RUN) || (state_q == DRAIN);
    assign boundary = running && (cnt_q == '0);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= PMIN;
            active_q <= PMIN;
            rev_q    <= '0;
            last1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            rev_q    <= rev_d;
            last1_q  <= last1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (m3r_enable) state_d = ARM;
            ARM:   state_d = RUN;
            RUN, DRAIN: begin
                if (m3r_enable)        state_d = RUN;
                else if (cnt_q == '0)  state_d = IDLE;
                else                   state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        shadow_d = m3r_periodLoad ? clamped : shadow_q;
        if ((state_q == ARM) || (boundary && m3r_enable)) begin
            cnt_d    = reload - CNT_W'(1);
            active_d = reload;
        end else if (boundary) begin
            cnt_d = '0;
        end else if (running) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Registered strobe: high in the cycle the counter sits at zero while stepping.
        last1_d = (cnt_d == '0) && ((state_d == RUN) || (state_d == DRAIN));
        rev_d   = rev_q + {{(REV_W-1){1'b0}}, wrap};
    end

    motoro3_step_index u_step_index (
        .clk_i  (clk),
        .rst_ni (nRst),
        .adv_i  (boundary),
        .dir_i  (m3r_dir),
        .step_o (m3step),
        .wrap_o (wrap)
    );

    always_comb begin
        m3cnt          = cnt_q;
        m3cntLast1     = last1_q;
        m3periodActive = active_q;
        m3revCnt       = rev_q;
        m3stepValid    = running;
        m3busy         = (state_q != IDLE);
    end

endmodule
